// File: rtl/bus_pkg.sv
// Shared definitions for the cpu data bus: address map, MMIO register
// offsets, STATUS bit positions and the UART transmitter state encoding.
package bus_pkg;

    // Width of a cpu data word; mirrors the cpu core's word width.
    localparam int WORD_WIDTH = 16;

    // First MMIO address; everything below it is data RAM (MMIO_BASE-1 is the stack top).
    localparam logic [WORD_WIDTH-1:0] MMIO_BASE = 16'hF800;

    // MMIO register offsets relative to MMIO_BASE.
    localparam logic [WORD_WIDTH-1:0] REG_TXDATA = 16'd0;
    localparam logic [WORD_WIDTH-1:0] REG_STATUS = 16'd1;

    // STATUS register bit positions.
    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_BUSY_BIT  = 2;
    localparam int STATUS_OVF_BIT   = 3;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/data_bus_uart_if.sv
// cpu data port plus the data RAM port, as seen by the bus splitter.
//
// Handshake: there is no valid/ready pair. A write commits on the single clk
// where cpu_stb & mem_write_en are both high; mem_write_en alone never causes
// an action. Reads are unqualified: data_in follows data_addr one clk later,
// and the cpu holds data_addr stable for at least 2 clk before cpu_stb.
interface data_bus_uart_if;

    logic                              cpu_stb;
    logic [bus_pkg::WORD_WIDTH-1:0]    data_addr;
    logic [bus_pkg::WORD_WIDTH-1:0]    data_out;
    logic                              mem_write_en;
    logic [bus_pkg::WORD_WIDTH-1:0]    data_in;

    logic [bus_pkg::WORD_WIDTH-1:0]    ram_addr;
    logic [bus_pkg::WORD_WIDTH-1:0]    ram_wdata;
    logic                              ram_wr_en;
    logic [bus_pkg::WORD_WIDTH-1:0]    ram_rdata;

    // cpu core and RAM side
    modport master (
        output cpu_stb, data_addr, data_out, mem_write_en, ram_rdata,
        input  data_in, ram_addr, ram_wdata, ram_wr_en
    );

    // bus splitter side
    modport slave (
        input  cpu_stb, data_addr, data_out, mem_write_en, ram_rdata,
        output data_in, ram_addr, ram_wdata, ram_wr_en
    );

endinterface

// File: rtl/data_bus_uart_fifo.sv
// Synchronous FIFO feeding the UART transmitter. A push while full is
// dropped here; the caller is responsible for flagging the overflow.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [WIDTH-1:0]          din,
    input  logic                      pop,
    output logic [WIDTH-1:0]          dout,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    wr_ptr;
    logic [CW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointers wrap modulo DEPTH; count tracks occupancy directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == CW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == CW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_bus_uart.sv
// Data bus splitter: RAM below MMIO_BASE, MMIO above it. The only MMIO
// peripheral is a FIFO-buffered 8N1 UART transmitter (TXDATA, STATUS).
module data_bus_uart #(
    parameter int                             FIFO_DEPTH   = 16,
    parameter int                             CLKS_PER_BIT = 63,
    parameter logic [bus_pkg::WORD_WIDTH-1:0] MMIO_BASE    = bus_pkg::MMIO_BASE
) (
    input  logic                 clk,
    input  logic                 rst,
    data_bus_uart_if.slave       bus,
    output logic                 uart_tx,
    output bus_pkg::uart_state_t state_dbg
);

    import bus_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic                  is_mmio;
    logic                  wr_commit;
    logic                  push;
    logic                  status_wr;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic                  busy;
    logic                  ovf;
    logic                  baud_done;
    logic [WORD_WIDTH-1:0] mmio_off;
    logic [WORD_WIDTH-1:0] mmio_val;
    logic [7:0]            fifo_dout;
    logic [CW-1:0]         fifo_count;
    logic [7:0]            shreg;
    logic [7:0]            shreg_n;
    logic [BW-1:0]         baud_cnt;
    logic [BW-1:0]         baud_n;
    logic [2:0]            bit_idx;
    logic [2:0]            bit_n;
    uart_state_t           state;
    uart_state_t           state_n;

    assign is_mmio   = (bus.data_addr >= MMIO_BASE);
    assign mmio_off  = bus.data_addr - MMIO_BASE;
    assign wr_commit = bus.cpu_stb & bus.mem_write_en;
    assign push      = wr_commit & is_mmio & (mmio_off == REG_TXDATA);
    assign status_wr = wr_commit & is_mmio & (mmio_off == REG_STATUS);

    assign bus.ram_addr  = bus.data_addr;
    assign bus.ram_wdata = bus.data_out;
    assign bus.ram_wr_en = wr_commit & ~is_mmio;

    assign busy      = (state != UART_IDLE) | (fifo_count != '0);
    assign baud_done = (baud_cnt == BW'(CLKS_PER_BIT - 1));
    assign state_dbg = state;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (bus.data_out[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // MMIO read mux; TXDATA and unmapped offsets read as zero.
    always_comb begin
        mmio_val = '0;
        if (mmio_off == REG_STATUS) begin
            mmio_val[STATUS_FULL_BIT]  = full;
            mmio_val[STATUS_EMPTY_BIT] = empty;
            mmio_val[STATUS_BUSY_BIT]  = busy;
            mmio_val[STATUS_OVF_BIT]   = ovf;
        end
    end

    // Registered read data, refreshed every clk regardless of cpu_stb.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.data_in <= '0;
        end else begin
            bus.data_in <= is_mmio ? mmio_val : bus.ram_rdata;
        end
    end

    // Sticky overflow flag; a dropped push beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (push & full) begin
            ovf <= 1'b1;
        end else if (status_wr & bus.data_out[STATUS_OVF_BIT]) begin
            ovf <= 1'b0;
        end
    end

    // UART state, baud counter, bit index and shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= UART_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            shreg    <= shreg_n;
        end
    end

    // UART next state and line level; the line is high except in START/DATA.
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_idx;
        shreg_n = shreg;
        pop     = 1'b0;
        uart_tx = 1'b1;
        case (state)
            UART_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_n = fifo_dout;
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = UART_START;
                end
            end
            UART_START: begin
                uart_tx = 1'b0;
                if (baud_done) begin
                    baud_n  = '0;
                    state_n = UART_DATA;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            UART_DATA: begin
                uart_tx = shreg[0];
                if (baud_done) begin
                    baud_n  = '0;
                    shreg_n = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        bit_n   = '0;
                        state_n = UART_STOP;
                    end else begin
                        bit_n = bit_idx + 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            UART_STOP: begin
                if (baud_done) begin
                    baud_n  = '0;
                    state_n = UART_IDLE;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            default: state_n = UART_IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_bus_uart.sv
// Directed bench for data_bus_uart with CLKS_PER_BIT=4 and a 16-deep FIFO.
module tb_data_bus_uart;

    import bus_pkg::*;

    localparam logic [15:0] A_TXDATA = 16'hF800;
    localparam logic [15:0] A_STATUS = 16'hF801;

    logic        clk;
    logic        rst;
    logic        uart_tx;
    uart_state_t state_dbg;

    data_bus_uart_if bus_if ();

    data_bus_uart #(
        .FIFO_DEPTH   (16),
        .CLKS_PER_BIT (4),
        .MMIO_BASE    (16'hF800)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .uart_tx   (uart_tx),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- RAM model (combinational read) ----------------
    logic [15:0] ram_mem [256];
    assign bus_if.ram_rdata = ram_mem[bus_if.ram_addr[7:0]];
    always @(posedge clk) begin
        if (bus_if.ram_wr_en) ram_mem[bus_if.ram_addr[7:0]] <= bus_if.ram_wdata;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected line waveform for one 8N1 frame at 4 clk/bit, sample 0 first.
    function automatic logic [39:0] frame_wave(input logic [7:0] b);
        logic [9:0]  bits;
        logic [39:0] w;
        bits = {1'b1, b, 1'b0};
        for (int j = 0; j < 10; j++)
            for (int k = 0; k < 4; k++)
                w[j*4 + k] = bits[j];
        return w;
    endfunction

    // ---------------- scoreboard / line monitor ----------------
    logic [7:0]  exp_q[$];
    logic [39:0] wave_q[$];
    int          gap_q[$];
    int          last_gap;
    logic [15:0] mid_status;

    initial begin
        logic [39:0] w;
        int          idle_run;
        bit          aborted;
        idle_run = 1000;
        forever begin
            @(negedge clk);
            if (rst) begin
                idle_run = 1000;
            end else if (uart_tx) begin
                idle_run++;
            end else begin
                w = '0;
                aborted = 1'b0;
                for (int k = 1; k < 40; k++) begin
                    @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    w[k] = uart_tx;
                    if (k == 20) mid_status = bus_if.data_in;
                end
                if (!aborted) begin
                    wave_q.push_back(w);
                    gap_q.push_back(idle_run);
                    idle_run = 0;
                end else begin
                    idle_run = 1000;
                end
            end
        end
    end

    task automatic wait_frames(input string tag, input int n);
        int waited;
        waited = 0;
        while (wave_q.size() < n && waited < n * 50 + 100) begin
            @(negedge clk);
            waited++;
        end
        check_eq({tag, "_frames_seen"}, 64'(wave_q.size() >= n), 64'd1);
    endtask

    task automatic expect_frames(input string tag, input int n);
        logic [7:0] b;
        wait_frames(tag, n);
        for (int i = 0; i < n; i++) begin
            if (wave_q.size() == 0 || exp_q.size() == 0) break;
            b = exp_q.pop_front();
            check_eq($sformatf("%s_frame%0d", tag, i), wave_q.pop_front(), frame_wave(b));
            last_gap = gap_q.pop_front();
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        bus_if.data_addr    = a;
        bus_if.data_out     = d;
        bus_if.mem_write_en = 1'b1;
        bus_if.cpu_stb      = 1'b1;
        @(negedge clk);
        bus_if.cpu_stb      = 1'b0;
        bus_if.mem_write_en = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk);
        bus_if.data_addr    = a;
        bus_if.cpu_stb      = 1'b0;
        bus_if.mem_write_en = 1'b0;
        @(negedge clk);
        d = bus_if.data_in;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic [15:0] rd;
        int          waited;

        for (int i = 0; i < 256; i++) ram_mem[i] = 16'hDEAD;
        bus_if.cpu_stb      = 1'b0;
        bus_if.data_addr    = 16'h0000;
        bus_if.data_out     = 16'h0000;
        bus_if.mem_write_en = 1'b0;
        last_gap            = -1;
        mid_status          = '0;
        rst                 = 1'b1;
        repeat (3) @(negedge clk);

        check_eq("reset_data_in", bus_if.data_in, 16'h0000);
        check_eq("reset_uart_tx", uart_tx, 1'b1);
        check_eq("reset_state", state_dbg, UART_IDLE);
        rst = 1'b0;

        // RAM passthrough write: ram_wr_en only while cpu_stb is high
        @(negedge clk);
        bus_if.data_addr    = 16'h0100;
        bus_if.data_out     = 16'h1234;
        bus_if.mem_write_en = 1'b1;
        bus_if.cpu_stb      = 1'b1;
        #1;
        check_eq("ram_wr_en_pulse", bus_if.ram_wr_en, 1'b1);
        check_eq("ram_addr", bus_if.ram_addr, 16'h0100);
        check_eq("ram_wdata", bus_if.ram_wdata, 16'h1234);
        @(negedge clk);
        bus_if.cpu_stb      = 1'b0;
        bus_if.mem_write_en = 1'b0;
        #1;
        check_eq("ram_wr_en_low", bus_if.ram_wr_en, 1'b0);
        cpu_read(16'h0100, rd);
        check_eq("ram_read_0100", rd, 16'h1234);
        cpu_read(A_STATUS, rd);
        check_eq("status_after_ram_wr", rd, 16'h0002);

        // Address map boundary and unmapped MMIO
        cpu_write(16'hF7FF, 16'hBEEF);
        cpu_read(16'hF7FF, rd);
        check_eq("ram_read_F7FF", rd, 16'hBEEF);
        cpu_read(A_TXDATA, rd);
        check_eq("txdata_reads_zero", rd, 16'h0000);
        cpu_write(16'hF805, 16'h00FF);
        cpu_read(16'hF805, rd);
        check_eq("unmapped_reads_zero", rd, 16'h0000);
        cpu_read(A_STATUS, rd);
        check_eq("unmapped_write_ignored", rd, 16'h0002);

        // Single byte 0x55: hand-derived line pattern, busy mid-frame
        cpu_write(A_TXDATA, 16'h0055);
        bus_if.data_addr = A_STATUS;
        wait_frames("single", 1);
        if (wave_q.size() > 0) begin
            check_eq("single_wave_55", wave_q.pop_front(), 40'hF0F0F0F0F0);
            last_gap = gap_q.pop_front();
        end
        check_eq("single_mid_status", mid_status, 16'h0006);
        cpu_read(A_STATUS, rd);
        check_eq("single_status_after", rd, 16'h0002);

        // Strobe qualification: write enable held 10 clk, one cpu_stb
        @(negedge clk);
        bus_if.data_addr    = A_TXDATA;
        bus_if.data_out     = 16'h0041;
        bus_if.mem_write_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus_if.cpu_stb = (i == 4);
            @(negedge clk);
        end
        bus_if.cpu_stb      = 1'b0;
        bus_if.mem_write_en = 1'b0;
        bus_if.data_addr    = A_STATUS;
        exp_q.push_back(8'h41);
        expect_frames("strobe", 1);
        repeat (60) @(negedge clk);
        check_eq("strobe_no_extra_frame", wave_q.size(), 0);
        cpu_read(A_STATUS, rd);
        check_eq("strobe_status_after", rd, 16'h0002);

        // Overflow: 18 back-to-back pushes; the first is popped at once,
        // the next 16 fill the FIFO, the 18th (0x21) is dropped.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            bus_if.data_addr    = A_TXDATA;
            bus_if.data_out     = 16'(8'h10 + i);
            bus_if.mem_write_en = 1'b1;
            bus_if.cpu_stb      = 1'b1;
            if (i < 17) exp_q.push_back(8'(8'h10 + i));
        end
        cpu_read(A_STATUS, rd);
        check_eq("ovf_status_full", rd, 16'h000D);
        expect_frames("ovf", 17);
        repeat (60) @(negedge clk);
        check_eq("ovf_dropped_not_sent", wave_q.size(), 0);
        cpu_read(A_STATUS, rd);
        check_eq("ovf_sticky", rd, 16'h000A);
        cpu_write(A_STATUS, 16'h0007);
        cpu_read(A_STATUS, rd);
        check_eq("ovf_not_cleared_bit3_0", rd, 16'h000A);
        cpu_write(A_STATUS, 16'h0008);
        cpu_read(A_STATUS, rd);
        check_eq("ovf_cleared", rd, 16'h0002);

        // Back-to-back frames with exactly one idle clk between them
        cpu_write(A_TXDATA, 16'h00A5);
        cpu_write(A_TXDATA, 16'h003C);
        bus_if.data_addr = A_STATUS;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        expect_frames("b2b", 2);
        check_eq("b2b_idle_gap", last_gap, 1);

        // Reset during DATA bit 3 of 0xC3
        cpu_write(A_TXDATA, 16'h00C3);
        bus_if.data_addr = A_STATUS;
        waited = 0;
        while (uart_tx && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check_eq("rst_frame_started", uart_tx, 1'b0);
        repeat (17) @(negedge clk);
        check_eq("rst_in_data_state", state_dbg, UART_DATA);
        check_eq("rst_bit3_level", uart_tx, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_line_high", uart_tx, 1'b1);
        check_eq("rst_data_in_zero", bus_if.data_in, 16'h0000);
        check_eq("rst_state_idle", state_dbg, UART_IDLE);
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_status_after", bus_if.data_in, 16'h0002);
        cpu_write(A_TXDATA, 16'h0096);
        bus_if.data_addr = A_STATUS;
        exp_q.push_back(8'h96);
        expect_frames("post_rst", 1);
        check_eq("post_rst_no_extra_frame", wave_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
